score_digit_addr_gen: RTL and testbench

Upstream address stage for the number sprite ROM/palette stage. Keeps the player's score as an NDIG-digit BCD counter, bumped by hit pulses, and snapshots it once per frame for display. For every scan position it computes the 10-bit pixel address of the matching digit glyph in the 600-entry number sprite sheet, plus a valid flag marking pixels inside the score box. The sprite sheet is 60 wide × 10 tall, 1 bpp, row-major, with glyphs 0–9 each 6×10 placed left to right.

---
 rtl/score_digit_addr_gen.sv | 149 ++++++++++++++
 tb/tb_score_digit_addr_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/score_digit_addr_gen.sv
// Score keeper and number-sprite address generator: BCD live score, per-frame display snapshot, 2-stage address pipe.
// Optional SCORE_LEADING_BLANK_EN blanks leading zero digits (LSD always shown); no backpressure, output every clk.
module score_digit_addr_gen #(
    parameter logic [9:0] X0          = 10'd280,
    parameter logic [9:0] Y0          = 10'd20,
    parameter int         NDIG        = 3,
    parameter int         SCALE_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              hit,
    input  logic              clear,
    output logic [9:0]        addr,
    output logic              addr_valid,
    output logic [4*NDIG-1:0] score_bcd,
    output logic              score_max
);

    localparam int                W     = 6 << SCALE_SHIFT;
    localparam int                H     = 10 << SCALE_SHIFT;
    localparam logic [10:0]       X_END = 11'(X0) + 11'(NDIG * W);
    localparam logic [10:0]       Y_END = 11'(Y0) + 11'(H);
    localparam logic [4*NDIG-1:0] ALL9  = {NDIG{4'h9}};

    logic [4*NDIG-1:0] score, score_inc, disp;
    logic              carry;

    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'h9) begin
                    score_inc[4*i +: 4] = 4'h0;
                end else begin
                    score_inc[4*i +: 4] = score[4*i +: 4] + 4'h1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign score_bcd = score;
    assign score_max = (score == ALL9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score <= '0;
            disp  <= '0;
        end else begin
            if (clear)
                score <= '0;
            else if (hit && !score_max)
                score <= score_inc;
            // registered read gives the pre-hit value on the snapshot cycle
            if (hcount == 10'd0 && vcount == 10'd0)
                disp <= score;
        end
    end

    // Stage 1: box test, digit index by compare chain, glyph row/col
    logic       in_box;
    logic [9:0] lx, ly, rem;
    logic [1:0] k_c;
    logic [2:0] col_c;
    logic [3:0] row_c;

    always_comb begin
        in_box = ({1'b0, hcount} >= 11'(X0)) && ({1'b0, hcount} < X_END) &&
                 ({1'b0, vcount} >= 11'(Y0)) && ({1'b0, vcount} < Y_END);
        lx  = hcount - X0;
        ly  = vcount - Y0;
        k_c = 2'd0;
        rem = lx;
        for (int i = 1; i < NDIG; i++) begin
            if (lx >= 10'(i * W)) begin
                k_c = 2'(i);
                rem = lx - 10'(i * W);
            end
        end
        col_c = 3'(rem >> SCALE_SHIFT);
        row_c = 4'(ly >> SCALE_SHIFT);
    end

    logic       s1_in;
    logic [1:0] s1_k;
    logic [2:0] s1_col;
    logic [3:0] s1_row;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_in  <= 1'b0;
            s1_k   <= 2'd0;
            s1_col <= 3'd0;
            s1_row <= 4'd0;
        end else begin
            s1_in  <= in_box;
            s1_k   <= k_c;
            s1_col <= col_c;
            s1_row <= row_c;
        end
    end

    // Stage 2: digit lookup and sprite-sheet address
    logic [3:0] d;
    logic [9:0] addr_c;
    logic       vld_c;
`ifdef SCORE_LEADING_BLANK_EN
    logic       lead_zero, blank;
`endif

    always_comb begin
        d = 4'h0;
`ifdef SCORE_LEADING_BLANK_EN
        lead_zero = 1'b1;
        blank     = 1'b0;
`endif
        for (int i = 0; i < NDIG; i++) begin
`ifdef SCORE_LEADING_BLANK_EN
            lead_zero = lead_zero && (disp[4*(NDIG-1-i) +: 4] == 4'h0);
`endif
            if (s1_k == 2'(i)) begin
                d = disp[4*(NDIG-1-i) +: 4];
`ifdef SCORE_LEADING_BLANK_EN
                blank = lead_zero && (i != NDIG - 1);
`endif
            end
        end
        addr_c = 10'(s1_row) * 10'd60 + 10'(d) * 10'd6 + 10'(s1_col);
`ifdef SCORE_LEADING_BLANK_EN
        vld_c = s1_in && !blank;
`else
        vld_c = s1_in;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr       <= 10'd0;
            addr_valid <= 1'b0;
        end else begin
            addr       <= s1_in ? addr_c : 10'd0;
            addr_valid <= vld_c;
        end
    end

endmodule

// File: tb/tb_score_digit_addr_gen.sv
// Scoreboard bench for score_digit_addr_gen: driver queues expected addr/valid, monitor compares 2 clk later.
module tb_score_digit_addr_gen;

`ifdef SCORE_LEADING_BLANK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount, vcount;
    logic        hit, clear;
    logic [9:0]  addr;
    logic        addr_valid;
    logic [11:0] score_bcd;
    logic        score_max;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         due;
        logic [9:0] a;
        logic       v;
        int         x;
        int         y;
    } exp_t;
    exp_t q[$];

    score_digit_addr_gen dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hit(hit), .clear(clear), .addr(addr), .addr_valid(addr_valid),
        .score_bcd(score_bcd), .score_max(score_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops every expectation that falls due this cycle
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.due != cyc || addr !== e.a || addr_valid !== e.v) begin
                bad++;
                $display("FAIL scan(%0d,%0d): got addr=%0d vld=%0b expected addr=%0d vld=%0b",
                         e.x, e.y, addr, addr_valid, e.a, e.v);
            end
        end
    end

    task automatic drive(input int x, input int y, input logic h, input logic c);
        @(negedge clk);
        hcount = 10'(x);
        vcount = 10'(y);
        hit    = h;
        clear  = c;
    endtask

    task automatic scan_exp(input int x, input int y, input int ea, input logic ev);
        exp_t e;
        drive(x, y, 1'b0, 1'b0);
        e.due = cyc + 2;
        e.a   = 10'(ea);
        e.v   = ev;
        e.x   = x;
        e.y   = y;
        q.push_back(e);
    endtask

    task automatic hits(input int n);
        repeat (n) drive(100, 100, 1'b1, 1'b0);
        drive(100, 100, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; hcount = 10'd0; vcount = 10'd0; hit = 1'b0; clear = 1'b0;
        #1;
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_vld", 32'(addr_valid), 32'd0);
        chk("reset_score", 32'(score_bcd), 32'h000);
        chk("reset_max", 32'(score_max), 32'd0);
        @(negedge clk) rst = 1'b1;

        // first pixel at score 0
        drive(0, 0, 1'b0, 1'b0);
        scan_exp(280, 20, 0, !LB);
        scan_exp(285, 20, 2, !LB);
        scan_exp(304, 20, 0, 1'b1);

        // deferred snapshot
        hits(12);
        chk("score_12", 32'(score_bcd), 32'h012);
        chk("max_12", 32'(score_max), 32'd0);
        scan_exp(299, 39, 543, !LB);
        drive(0, 0, 1'b0, 1'b0);
        scan_exp(299, 39, 549, 1'b1);
        scan_exp(315, 39, 557, 1'b1);

        // boundaries
        scan_exp(279, 25, 0, 1'b0);
        scan_exp(316, 25, 0, 1'b0);
        scan_exp(290, 19, 0, 1'b0);
        scan_exp(290, 40, 0, 1'b0);

        // hit and clear together
        hits(111);
        chk("score_123", 32'(score_bcd), 32'h123);
        drive(100, 100, 1'b1, 1'b1);
        drive(100, 100, 1'b0, 1'b0);
        chk("hitclr_score", 32'(score_bcd), 32'h000);
        chk("hitclr_max", 32'(score_max), 32'd0);

        // saturation
        hits(1000);
        chk("sat_score", 32'(score_bcd), 32'h999);
        chk("sat_max", 32'(score_max), 32'd1);
        hits(1);
        chk("sat_hold", 32'(score_bcd), 32'h999);
        drive(0, 0, 1'b0, 1'b0);
        scan_exp(315, 39, 599, 1'b1);
        scan_exp(280, 20, 54, 1'b1);

        // async reset mid-frame with live score 0x042, display 999
        drive(100, 100, 1'b0, 1'b1);
        hits(42);
        chk("score_42", 32'(score_bcd), 32'h042);
        scan_exp(280, 20, 54, 1'b1);
        repeat (4) drive(280, 20, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_addr", 32'(addr), 32'd0);
        chk("async_vld", 32'(addr_valid), 32'd0);
        chk("async_score", 32'(score_bcd), 32'h000);
        chk("async_max", 32'(score_max), 32'd0);
        @(negedge clk) rst = 1'b1;

        // display stays 0 until the next snapshot
        hits(5);
        chk("score_5", 32'(score_bcd), 32'h005);
        scan_exp(315, 39, 545, 1'b1);
        drive(0, 0, 1'b0, 1'b0);
        scan_exp(315, 39, 575, 1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expectations still pending, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
